isqrt_seq: RTL

Sequential integer square-root unit: accepts a 2·BITWIDTH-bit operand and returns the BITWIDTH-bit floor root and the remainder (x − root²). It computes one root bit per cycle using the restoring digit-by-digit method. In the trial-factoring datapath it is the inverse companion of the squarer: it bounds candidate factor ranges (k_max ≈ √N) and provides a root-based self-check on squarer output.

---
 rtl/isqrt_seq_if.sv | 32 +++
 rtl/isqrt_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/isqrt_seq_if.sv
// Handshake bundle for isqrt_seq: operand channel (in_*, x) and result channel (out_*, root, rem).
interface isqrt_seq_if #(
    parameter int unsigned BITWIDTH = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [2*BITWIDTH-1:0]   x;
    logic                    out_valid;
    logic                    out_ready;
    logic [BITWIDTH-1:0]     root;
    logic [BITWIDTH:0]       rem;

    modport master (
        output in_valid,
        output x,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  root,
        input  rem
    );

    modport slave (
        input  in_valid,
        input  x,
        input  out_ready,
        output in_ready,
        output out_valid,
        output root,
        output rem
    );
endinterface

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root, one root bit per cycle.
// Optional ISQRT_EARLY_EXIT_EN skips leading all-zero bit-pairs of the operand.
module isqrt_seq #(
    parameter int unsigned BITWIDTH = 32
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    isqrt_seq_if.slave bus_io
);

    localparam int unsigned XW = 2 * BITWIDTH;
    localparam int unsigned AW = BITWIDTH + 2;
    localparam int unsigned IW = $clog2(BITWIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [BITWIDTH-1:0]   q_q, q_d;
    logic [IW-1:0]         iter_q, iter_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [BITWIDTH-1:0]   root_q, root_d;
    logic [BITWIDTH:0]     rem_q, rem_d;

    logic [IW-1:0]         start_iter;
    logic [AW-1:0]         acc_sh;
    logic [AW-1:0]         trial;
    logic                  ge;
    logic [AW-1:0]         acc_nx;
    logic [BITWIDTH-1:0]   q_nx;

`ifdef ISQRT_EARLY_EXIT_EN
    int unsigned lz;
    logic        found;

    // Leading zero pairs leave acc and q at zero, so they can be skipped outright.
    // x==0 saturates to a single iteration over the lowest pair.
    always_comb begin
        lz    = 0;
        found = 1'b0;
        for (int i = BITWIDTH - 1; i >= 0; i--) begin
            if (!found && bus_io.x[2*i +: 2] == 2'b00) begin
                lz = lz + 1;
            end else begin
                found = 1'b1;
            end
        end
        if (lz >= BITWIDTH) begin
            lz = BITWIDTH - 1;
        end
        start_iter = IW'(BITWIDTH - 1 - lz);
    end
`else
    assign start_iter = IW'(BITWIDTH - 1);
`endif

    // One restoring step on the pair selected by iter_q.
    always_comb begin
        acc_sh = AW'({acc_q, x_q[{iter_q, 1'b0} +: 2]});
        trial  = {q_q, 2'b01};
        ge     = (acc_sh >= trial);
        acc_nx = ge ? (acc_sh - trial) : acc_sh;
        q_nx   = {q_q[BITWIDTH-2:0], ge};
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        acc_d       = acc_q;
        q_d         = q_q;
        iter_d      = iter_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        root_d      = root_q;
        rem_d       = rem_q;

        unique case (state_q)
            StIdle: begin
                if (bus_io.in_valid && in_ready_q) begin
                    x_d        = bus_io.x;
                    acc_d      = '0;
                    q_d        = '0;
                    iter_d     = start_iter;
                    in_ready_d = 1'b0;
                    state_d    = StCalc;
                end
            end
            StCalc: begin
                acc_d = acc_nx;
                q_d   = q_nx;
                if (iter_q == '0) begin
                    root_d      = q_nx;
                    rem_d       = acc_nx[BITWIDTH:0];
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    iter_d = iter_q - 1'b1;
                end
            end
            StDone: begin
                if (bus_io.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            x_q         <= '0;
            acc_q       <= '0;
            q_q         <= '0;
            iter_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            root_q      <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            q_q         <= q_d;
            iter_q      <= iter_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            root_q      <= root_d;
            rem_q       <= rem_d;
        end
    end

    assign bus_io.in_ready  = in_ready_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.root      = root_q;
    assign bus_io.rem       = rem_q;

endmodule
